led_seq_ctrl: RTL
=================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 4, meaning clock cycles each vector is held; legal values 1..255.
REQ-002 Parameter: NUM_VEC, default 4, meaning number of table entries sequenced; legal values 1..4.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  begins a sequence when sampled high in IDLE.
REQ-006 Port: pause  input  1  level; freezes the sequence while high.
REQ-007 Port: abort  input  1  terminates the sequence and returns to IDLE.
REQ-008 Port: led_i  input  8  result from the combinational LED datapath.
REQ-009 Port: key_o  output  4  key vector driven to the datapath.
REQ-010 Port: sw_o  output  4  sw vector driven to the datapath.
REQ-011 Port: led_cap  output  8  last captured led_i.
REQ-012 Port: idx  output  2  index of the vector currently driven.
REQ-013 Port: busy  output  1  high in RUN.
REQ-014 Port: done  output  1  one-cycle pulse at sequence completion.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE, all registered.
REQ-016 In IDLE: key_o=0, sw_o=0, idx=0, busy=0, done=0, led_cap holds its value.
REQ-017 start=1 in IDLE: next cycle RUN, idx=0, key_o/sw_o = table[0], hold counter=0.
REQ-018 In RUN, hold counter increments each unpaused cycle; at count TICK_DIV-1, led_cap <= led_i on that edge.
REQ-019 On that same edge, if idx<NUM_VEC-1: idx+1, outputs = table[idx+1], counter=0; else go to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, key_o/sw_o=0, then IDLE.
REQ-021 Each vector SHALL be driven for exactly TICK_DIV unpaused cycles; sequence latency start-to-done = NUM_VEC*TICK_DIV+1 cycles.
REQ-022 pause=1 in RUN freezes counter, idx, key_o, sw_o, led_cap; no capture occurs while paused.
REQ-023 pause SHALL have no effect in IDLE or DONE.
REQ-024 abort=1 in RUN or DONE: next cycle IDLE, done stays 0, led_cap unchanged.
REQ-025 Priority: rst > abort > pause > counter/capture; start while busy or in DONE SHALL be ignored.
REQ-026 start and abort both high in IDLE: remain IDLE.
REQ-027 Counter width 8 bits; no wrap occurs within legal TICK_DIV.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, key_o=0, sw_o=0, idx=0, led_cap=0, busy=0, done=0, counter=0.
REQ-029 rst asserted mid-RUN SHALL discard the sequence without a done pulse.

Configuration
REQ-030 Macro LED_SEQ_LOOP_EN defined: after the last vector's capture, idx wraps to 0 and RUN continues; done pulses one cycle on each wrap while busy stays 1; only abort or rst exits.
REQ-031 Macro LED_SEQ_LOOP_EN undefined: behaviour per REQ-019/020 (single pass).

Structure
REQ-032 Package led_seq_pkg SHALL hold the state enum and the vector table: {key,sw} = {1010,0101}, {1111,0000}, {0011,1100}, {1001,0110}, indices 0..3.
REQ-033 Hold counter and terminal-count decode SHALL be a sub-module led_seq_tick (inputs clr, en; output tc).

Verification (TICK_DIV=4, NUM_VEC=4, led_i = {key_o,sw_o} model)
REQ-034 rst 2 cycles then start pulse -> key_o/sw_o step 1010/0101, 1111/0000, 0011/1100, 1001/0110 every 4 cycles; done at cycle 17 after start; led_cap=10010110.
REQ-035 pause high 3 cycles during idx=1 -> idx=1 held 7 cycles total, done delayed by 3 cycles.
REQ-036 abort at idx=2 -> next cycle IDLE, key_o=0, no done, led_cap=11110000.
REQ-037 start pulsed again mid-RUN and start+abort together in IDLE -> no restart, state unchanged.
REQ-038 rst mid-RUN at idx=3 -> all outputs 0 next cycle, no done.
REQ-039 LED_SEQ_LOOP_EN defined, 40 cycles -> idx wraps 3->0, done pulses at cycles 17 and 33, busy stays 1.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: FSM state encoding and the fixed key/sw vector table.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] key;
        logic [3:0] sw;
    } vec_t;

    function automatic vec_t vec_lookup(input logic [1:0] i);
        vec_t v;
        case (i)
            2'd0:    v = '{key: 4'b1010, sw: 4'b0101};
            2'd1:    v = '{key: 4'b1111, sw: 4'b0000};
            2'd2:    v = '{key: 4'b0011, sw: 4'b1100};
            default: v = '{key: 4'b1001, sw: 4'b0110};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/led_seq_if.sv
// Control and datapath bundle between the LED sequencer and its environment.
interface led_seq_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic [7:0] led_i;
    logic [3:0] key_o;
    logic [3:0] sw_o;
    logic [7:0] led_cap;
    logic [1:0] idx;
    logic       busy;
    logic       done;

    modport master (
        output start, pause, abort, led_i,
        input  key_o, sw_o, led_cap, idx, busy, done
    );

    modport slave (
        input  start, pause, abort, led_i,
        output key_o, sw_o, led_cap, idx, busy, done
    );
endinterface

// File: rtl/led_seq_tick.sv
// Hold counter: counts enabled cycles, flags the last cycle of a TICK_DIV hold period.
// tc is combinational from the registered count and en; clr wins over en.
module led_seq_tick #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [7:0] TC_VAL = 8'(TICK_DIV - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 8'd0;
        else if (clr)
            cnt_q <= 8'd0;
        else if (en)
            cnt_q <= cnt_q + 8'd1;
    end

    assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: steps key/sw vectors into the datapath, capturing led_i at the end of each hold.
// Build option LED_SEQ_LOOP_EN: wrap to vector 0 forever, pulsing done per pass (abort/rst exit).
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int NUM_VEC  = 4
) (
    input logic     clk,
    input logic     rst,
    led_seq_if.slave bus
);
    localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cap_q, cap_d;
    logic       done_q, done_d;
    logic       run;
    logic       cnt_en, cnt_clr, tc;
    vec_t       cur;

    assign run = (state_q == ST_RUN);

    // abort outranks pause, and a terminal count always restarts the hold period
    assign cnt_en  = run && !bus.abort && !bus.pause;
    assign cnt_clr = !run || bus.abort || tc;

    led_seq_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cap_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ST_RUN;
                    idx_d   = 2'd0;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                end else if (tc) begin
                    cap_d = bus.led_i;
                    if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
                        idx_d  = 2'd0;
`ifdef LED_SEQ_LOOP_EN
                        state_d = ST_RUN;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    assign cur         = vec_lookup(idx_q);
    assign bus.key_o   = run ? cur.key : 4'd0;
    assign bus.sw_o    = run ? cur.sw  : 4'd0;
    assign bus.idx     = run ? idx_q   : 2'd0;
    assign bus.led_cap = cap_q;
    assign bus.busy    = run;
    assign bus.done    = done_q;

endmodule
